// File: rtl/icache_assoc_if.sv
// icache_assoc_if: fetch-side, data-side arbitration, memory-side and
// performance-counter signals of the set-associative instruction cache.
// The cache sits on the slave modport; the fetch stage and arbiter use master.
interface icache_assoc_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        dmemREN;
  logic        dmemWEN;
  logic        halt;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  modport slave (
    input  imemREN, imemaddr, dmemREN, dmemWEN, halt, iwait, iload,
    output ihit, imemload, iREN, iaddr, hit_count, miss_count
  );

  modport master (
    output imemREN, imemaddr, dmemREN, dmemWEN, halt, iwait, iload,
    input  ihit, imemload, iREN, iaddr, hit_count, miss_count
  );
endinterface

// File: rtl/icache_assoc.sv
// icache_assoc: set-associative instruction cache with multi-word block fill.
// Replacement: LRU bit (WAYS=2) or 3-bit tree-PLRU (WAYS=4) per set.
// Optional feature macro: ICACHE_PERF_EN builds the hit/miss counters;
// without it both counters read 0.
module icache_assoc #(
  parameter int WAYS = 2,
  parameter int SETS = 8,
  parameter int WPB  = 2
) (
  input logic CLK,
  input logic RST,
  icache_assoc_if.slave bus
);
  localparam int OFF_BITS = $clog2(WPB);
  localparam int OFF_W    = (WPB > 1) ? OFF_BITS : 1;
  localparam int IDX_W    = $clog2(SETS);
  localparam int TAG_W    = 30 - OFF_BITS - IDX_W;
  localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int REPL_W   = (WAYS == 4) ? 3 : 1;

  typedef enum logic {S_IDLE, S_FILL} state_t;
  state_t state_q, state_d;

  logic [WAYS-1:0]   valid_q [SETS];
  logic [REPL_W-1:0] repl_q  [SETS];
  logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
  logic [31:0]       data_q  [WAYS][SETS][WPB];

  logic [29:0]      fill_base;
  logic [WAY_W-1:0] victim_q;
  logic [OFF_W-1:0] cnt_q;
  logic [31:0]      last_q;

  // Marks way w most-recently used; bits point toward the LRU side.
  function automatic logic [2:0] touch(input logic [2:0] r, input logic [1:0] w);
    logic [2:0] n;
    n = r;
    if (WAYS == 2) n[0] = ~w[0];
    else if (WAYS == 4) begin
      n[0] = ~w[1];
      if (w[1]) n[2] = ~w[0];
      else      n[1] = ~w[0];
    end
    return n;
  endfunction

  // Follows the replacement bits to the least-recently-used way.
  function automatic logic [1:0] lru_way(input logic [2:0] r);
    if (WAYS == 2) return {1'b0, r[0]};
    if (WAYS == 4) return r[0] ? {1'b1, r[2]} : {1'b0, r[1]};
    return 2'd0;
  endfunction

  logic [29:0]      req_word;
  logic [OFF_W-1:0] req_off;
  logic [IDX_W-1:0] req_idx, fill_idx;
  logic [TAG_W-1:0] req_tag, fill_tag;
  logic             blocked, last_word;
  logic             unused_addr_bits;

  assign req_word  = bus.imemaddr[31:2];
  assign req_off   = OFF_W'(req_word & 30'(WPB - 1));
  assign req_idx   = IDX_W'(req_word >> OFF_BITS);
  assign req_tag   = TAG_W'(req_word >> (OFF_BITS + IDX_W));
  assign fill_idx  = IDX_W'(fill_base >> OFF_BITS);
  assign fill_tag  = TAG_W'(fill_base >> (OFF_BITS + IDX_W));
  assign blocked   = bus.dmemREN | bus.dmemWEN | bus.halt;
  assign last_word = (cnt_q == OFF_W'(WPB - 1));
  assign unused_addr_bits = ^bus.imemaddr[1:0];

  logic             hit_any;
  logic [WAY_W-1:0] hit_way, victim;
  logic [31:0]      hit_word;

  // Parallel tag lookup across all ways of the requested set.
  // NOTE: always_comb with every output given a default first keeps this
  // purely combinational; a missing default would infer a latch.
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[req_idx][w] && tag_q[w][req_idx] == req_tag) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    hit_word = data_q[hit_way][req_idx][req_off];
  end

  // Victim: lowest-numbered invalid way, else the LRU/PLRU way.
  always_comb begin
    victim = WAY_W'(lru_way(3'(repl_q[req_idx])));
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[req_idx][w]) victim = WAY_W'(w);
    end
  end

  logic        do_hit, do_miss, accept, abort;
  logic        ihit, iren;
  logic [31:0] iaddr, imemload;

  // Next-state and output decode for the IDLE/FILL controller.
  always_comb begin
    state_d  = state_q;
    ihit     = 1'b0;
    iren     = 1'b0;
    iaddr    = '0;
    imemload = last_q;
    do_hit   = 1'b0;
    do_miss  = 1'b0;
    accept   = 1'b0;
    abort    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!blocked && bus.imemREN) begin
          if (hit_any) begin
            ihit     = 1'b1;
            imemload = hit_word;
            do_hit   = 1'b1;
          end else begin
            do_miss = 1'b1;
            state_d = S_FILL;
          end
        end
      end
      S_FILL: begin
        iaddr = {fill_base | 30'(cnt_q), 2'b00};
        if (bus.halt) begin
          abort   = 1'b1;
          state_d = S_IDLE;
        end else if (!blocked) begin
          iren   = 1'b1;
          accept = !bus.iwait;
          if (accept && last_word) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.ihit     = ihit;
  assign bus.iREN     = iren;
  assign bus.iaddr    = iaddr;
  assign bus.imemload = imemload;

  // Controller state register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Valid bits, replacement state, fill bookkeeping and last instruction.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        repl_q[s]  <= '0;
      end
      cnt_q     <= '0;
      last_q    <= '0;
      fill_base <= '0;
      victim_q  <= '0;
    end else begin
      if (do_hit) begin
        last_q          <= hit_word;
        repl_q[req_idx] <= REPL_W'(touch(3'(repl_q[req_idx]), 2'(hit_way)));
      end
      if (do_miss) begin
        fill_base <= req_word & ~30'(WPB - 1);
        victim_q  <= victim;
        cnt_q     <= '0;
      end
      if (abort) begin
        valid_q[fill_idx][victim_q] <= 1'b0;
        cnt_q                       <= '0;
      end
      if (accept) begin
        if (last_word) begin
          valid_q[fill_idx][victim_q] <= 1'b1;
          repl_q[fill_idx] <= REPL_W'(touch(3'(repl_q[fill_idx]), 2'(victim_q)));
          cnt_q            <= '0;
        end else begin
          cnt_q <= cnt_q + OFF_W'(1);
        end
      end
    end
  end

  // Line data and tag storage.
  // NOTE: the arrays are deliberately not reset; the valid bits alone decide
  // whether their contents are ever used, so they map onto plain RAM.
  always_ff @(posedge CLK) begin
    if (accept) begin
      data_q[victim_q][fill_idx][cnt_q] <= bus.iload;
      if (last_word) tag_q[victim_q][fill_idx] <= fill_tag;
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  // Performance counters: one per IDLE hit cycle, one per miss entering FILL.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (do_hit)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (do_miss) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign bus.hit_count  = hit_cnt_q;
  assign bus.miss_count = miss_cnt_q;
`else
  assign bus.hit_count  = '0;
  assign bus.miss_count = '0;
`endif
endmodule

// File: tb/tb_icache_assoc.sv
// tb_icache_assoc: directed and randomized checks of icache_assoc against a
// timestamp-LRU reference model of the cache contents.
module tb_icache_assoc;
  localparam int WAYS = 2;
  localparam int SETS = 8;
  localparam int WPB  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  icache_assoc_if bus ();

  icache_assoc #(.WAYS(WAYS), .SETS(SETS), .WPB(WPB)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  // Backing memory: every word address returns a distinct pattern.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction
  assign bus.iload = mem_word(bus.iaddr);

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: per-set ways with valid/tag and a last-use timestamp.
  bit          m_valid [SETS][WAYS];
  int          m_tag   [SETS][WAYS];
  int          m_stamp [SETS][WAYS];
  int          now = 0;
  logic [31:0] m_last = '0;
  int          m_hits = 0;
  int          m_misses = 0;

  function automatic int a_idx(input logic [31:0] a);
    return int'((a >> 2) / WPB) % SETS;
  endfunction

  function automatic int a_tag(input logic [31:0] a);
    return int'((a >> 2) / (WPB * SETS));
  endfunction

  function automatic int m_lookup(input logic [31:0] a);
    for (int w = 0; w < WAYS; w++)
      if (m_valid[a_idx(a)][w] && m_tag[a_idx(a)][w] == a_tag(a)) return w;
    return -1;
  endfunction

  function automatic int m_victim(input int idx);
    int v;
    for (int w = 0; w < WAYS; w++) if (!m_valid[idx][w]) return w;
    v = 0;
    for (int w = 1; w < WAYS; w++) if (m_stamp[idx][w] < m_stamp[idx][v]) v = w;
    return v;
  endfunction

  task automatic m_use(input int idx, input int way);
    now++;
    m_stamp[idx][way] = now;
  endtask

  task automatic m_reset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 1'b0;
        m_stamp[s][w] = 0;
      end
    m_last = '0;
    m_hits = 0;
    m_misses = 0;
  endtask

  typedef enum {M_PLAIN, M_RAND, M_STALL, M_HALT, M_RESET} mode_t;

  task automatic drive_idle();
    bus.imemREN = 1'b0;
    bus.dmemREN = 1'b0;
    bus.dmemWEN = 1'b0;
    bus.halt    = 1'b0;
    bus.iwait   = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    drive_idle();
    #1;
    check("idle_ihit", bus.ihit, 1'b0);
    check("idle_iren", bus.iREN, 1'b0);
    check("idle_load", bus.imemload, m_last);
    @(posedge clk);
  endtask

  task automatic check_perf();
`ifdef ICACHE_PERF_EN
    check("hit_count", bus.hit_count, m_hits);
    check("miss_count", bus.miss_count, m_misses);
`else
    check("hit_count", bus.hit_count, 32'd0);
    check("miss_count", bus.miss_count, 32'd0);
`endif
  endtask

  // One fetch: hit in place, or miss + block fill + hit on the next cycle.
  task automatic fetch(input logic [31:0] addr, input mode_t mode);
    int          idx, way, vic, k, cyc, stall_left;
    logic [31:0] base, word;
    bit          blk, iw;
    idx  = a_idx(addr);
    way  = m_lookup(addr);
    word = addr & ~32'h3;
    base = word & ~32'(WPB * 4 - 1);
    @(negedge clk);
    drive_idle();
    bus.imemREN  = 1'b1;
    bus.imemaddr = addr;
    #1;
    check("req_hit", bus.ihit, way >= 0);
    if (way >= 0) begin
      check("hit_data", bus.imemload, mem_word(word));
      m_use(idx, way);
      m_hits++;
      m_last = mem_word(word);
      @(posedge clk);
      return;
    end
    check("miss_iren", bus.iREN, 1'b0);
    check("miss_load", bus.imemload, m_last);
    m_misses++;
    vic = m_victim(idx);
    @(posedge clk);
    k = 0;
    cyc = 0;
    stall_left = 3;
    while (k < WPB && cyc < 64) begin
      @(negedge clk);
      cyc++;
      blk = 1'b0;
      iw  = 1'b0;
      if (k == 1 && mode == M_HALT) begin
        bus.halt = 1'b1;
        #1;
        check("halt_iren", bus.iREN, 1'b0);
        check("halt_ihit", bus.ihit, 1'b0);
        @(posedge clk);
        m_valid[idx][vic] = 1'b0;
        idle_cycle();
        return;
      end
      if (k == 1 && mode == M_RESET) begin
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive_idle();
        #1;
        check("rst_ihit", bus.ihit, 1'b0);
        check("rst_load", bus.imemload, 32'd0);
        check("rst_iren", bus.iREN, 1'b0);
        check("rst_iaddr", bus.iaddr, 32'd0);
        check("rst_hits", bus.hit_count, 32'd0);
        check("rst_misses", bus.miss_count, 32'd0);
        m_reset();
        @(posedge clk);
        return;
      end
      if (mode == M_STALL && k == 1 && stall_left > 0) begin
        blk = 1'b1;
        stall_left--;
      end
      if (mode == M_RAND) begin
        blk = ($urandom_range(0, 3) == 0);
        iw  = 1'($urandom_range(0, 1));
        bus.imemaddr = $urandom;
      end
      bus.dmemREN = blk;
      bus.iwait   = iw;
      #1;
      check("fill_iren", bus.iREN, !blk);
      check("fill_ihit", bus.ihit, 1'b0);
      if (!blk) begin
        check("fill_iaddr", bus.iaddr, base + 32'(4 * k));
        if (!iw) k++;
      end
      @(posedge clk);
    end
    if (k < WPB) begin
      total++;
      bad++;
      $error("FAIL fill_budget: observed %0d words expected %0d", k, WPB);
    end
    m_valid[idx][vic] = 1'b1;
    m_tag[idx][vic]   = a_tag(addr);
    m_use(idx, vic);
    @(negedge clk);
    drive_idle();
    bus.imemREN  = 1'b1;
    bus.imemaddr = addr;
    #1;
    check("post_fill_hit", bus.ihit, 1'b1);
    check("post_fill_data", bus.imemload, mem_word(word));
    m_use(idx, vic);
    m_hits++;
    m_last = mem_word(word);
    @(posedge clk);
  endtask

  initial begin
    logic [31:0] a;
    rst = 1'b1;
    bus.imemaddr = '0;
    drive_idle();
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset_ihit", bus.ihit, 1'b0);
    check("reset_load", bus.imemload, 32'd0);
    check("reset_iren", bus.iREN, 1'b0);
    check("reset_iaddr", bus.iaddr, 32'd0);
    check("reset_hits", bus.hit_count, 32'd0);
    check("reset_misses", bus.miss_count, 32'd0);
    rst = 1'b0;

    // Cold miss then same-block hit.
    fetch(32'h0000_0040, M_PLAIN);
    fetch(32'h0000_0044, M_PLAIN);
    check_perf();

    // Conflict in set 0: tags 1, 9, 17 with a re-touch of tag 9.
    fetch(32'h0000_0240, M_PLAIN);
    fetch(32'h0000_0240, M_PLAIN);
    fetch(32'h0000_0440, M_PLAIN);
    fetch(32'h0000_0240, M_PLAIN);
    fetch(32'h0000_0040, M_PLAIN);

    // Data-side stall in the middle of a fill.
    fetch(32'h0000_0048, M_STALL);
    fetch(32'h0000_004C, M_PLAIN);

    // Halt abort, then the same block refills completely.
    fetch(32'h0000_0088, M_HALT);
    fetch(32'h0000_0088, M_PLAIN);
    check_perf();

    // Reset in the middle of a fill; earlier lines are gone.
    fetch(32'h0000_00C8, M_RESET);
    fetch(32'h0000_0240, M_PLAIN);
    fetch(32'h0000_0048, M_PLAIN);
    check_perf();

    // Random traffic over a small address pool.
    for (int i = 0; i < 300; i++) begin
      a = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 7)) << 3)
        | (32'($urandom_range(0, 1)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) begin
        @(negedge clk);
        drive_idle();
        bus.imemREN  = 1'b1;
        bus.imemaddr = a;
        bus.dmemWEN  = 1'b1;
        #1;
        check("blocked_ihit", bus.ihit, 1'b0);
        check("blocked_iren", bus.iREN, 1'b0);
        check("blocked_load", bus.imemload, m_last);
        @(posedge clk);
      end
      fetch(a, M_RAND);
    end
    idle_cycle();
    check_perf();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/icache_assoc.md
# icache_assoc

Parametrised set-associative instruction cache that replaces the direct-mapped, one-word-per-line icache between the datapath fetch stage and the memory arbiter. It supports configurable ways, sets and words per block, LRU/tree-PLRU replacement and a multi-word block-fill state machine. It gives priority to data-side memory traffic and halt, in the same way as the existing fetch path.

## Interface
Parameters:
- WAYS, 2, associativity; legal values are 1, 2, 4.
- SETS, 8, sets per way; power of two, 2..64.
- WPB, 2, 32-bit words per block; legal values are 1, 2, 4.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset; synchronous, active-high.
- imemREN  in  1  datapath fetch request.
- imemaddr  in  32  fetch byte address; bits [1:0] are ignored.
- dmemREN  in  1  data read pending; suppresses the instruction side.
- dmemWEN  in  1  data write pending; suppresses the instruction side.
- halt  in  1  CPU halted.
- ihit  out  1  imemload is valid this cycle.
- imemload  out  32  fetched instruction.
- iREN  out  1  memory read request to the arbiter.
- iaddr  out  32  memory word address.
- iwait  in  1  memory busy; a word is accepted when iREN=1 and iwait=0.
- iload  in  32  memory read data.
- hit_count  out  32  performance counter (see Configuration).
- miss_count  out  32  performance counter (see Configuration).

## Operation
- Address split: byte [1:0]; word offset of log2(WPB) bits; index of log2(SETS) bits; tag is the remaining upper bits.
- Each way/set entry holds: valid, tag, WPB data words. Each set also holds replacement state: 1 LRU bit for WAYS=2, 3-bit tree-PLRU for WAYS=4, none for WAYS=1.
- Blocked condition: dmemREN | dmemWEN | halt.
- State IDLE:
  - If not blocked and imemREN=1, look up all ways in parallel.
  - Hit: ihit=1, imemload is the matching word, replacement state marks the hit way most-recently used, the last-instruction register is loaded.
  - Miss: latch the block address and select the victim, then go to FILL.
  - Victim selection: lowest-numbered invalid way; otherwise the LRU/PLRU way.
- State FILL:
  - iREN=1 and iaddr={latched block, cnt, 2'b00}, with cnt running 0..WPB-1.
  - On each accepted word: write it into the victim's data slot cnt, then cnt++.
  - After the last word: set valid, write the tag, mark the victim MRU, return to IDLE.
- While blocked in FILL: iREN=0; cnt and words already received are held; the fill resumes when unblocked.
- halt=1 in FILL: abort to IDLE. The victim's valid bit is cleared and no partial line is ever marked valid.
- imemaddr changing during FILL has no effect; the latched block is completed.
- Outside a hit: ihit=0 and imemload holds the last-instruction register.
- Reset (including mid-FILL): all valid bits and replacement state cleared, state IDLE, cnt=0.
- Reset values: ihit=0, imemload=0, iREN=0, iaddr=0, hit_count=0, miss_count=0.

## Timing
- Hit: combinational; ihit in the same cycle as the request, zero latency.
- Miss: the IDLE cycle detecting the miss has ihit=0 and iREN=0. FILL starts the next cycle. After the final word is accepted, the next cycle is IDLE and hits.
- Miss latency = 1 + Σ(per-word cycles until iwait=0) + 1 cycles.
- Line write, valid, tag and replacement updates take effect on the clock edge that accepts the final word.
- Replacement state updates only on an IDLE hit or on fill completion.

## Configuration
- ICACHE_PERF_EN defined:
  - hit_count increments on each cycle with ihit=1 in IDLE.
  - miss_count increments once per IDLE miss entering FILL.
  - Both are 32-bit, wrap modulo 2^32, and reset to 0.
- ICACHE_PERF_EN undefined: hit_count and miss_count are tied to 0 and no counter logic is built.

## Test plan
- Cold miss, WAYS=2 SETS=8 WPB=2, iwait=0: request 0x0000_0040 -> FILL issues iaddr 0x40 then 0x44. Next cycle ihit=1 with the 0x40 data; request 0x44 -> hit with zero latency; miss_count=1.
- Conflict: fill 0x040, 0x240, 0x440 (same index 0, tags 1, 9, 17), then re-touch 0x240 before 0x440 -> 0x440 evicts way holding tag 1. Requesting 0x040 then misses; 0x240 still hits.
- Arbitration: assert dmemREN during FILL at cnt=1 for 3 cycles -> iREN=0 for those cycles, cnt holds, fill completes correctly once dmemREN drops.
- Halt mid-fill: halt=1 after the first word -> IDLE, iREN=0, ihit=0; re-requesting the same address misses again and performs a full fill.
- Reset mid-fill: RST=1 for 1 cycle -> all outputs 0; previously valid addresses miss.
- With ICACHE_PERF_EN: 10 hits and 3 misses -> hit_count=10, miss_count=3. Without the macro both read 0.
